// File: rtl/sky130_fd_io__amuxbus_arbiter.sv
// sky130_fd_io__amuxbus_arbiter
//   Shares AMUXBUS_A / AMUXBUS_B among NREQ requesters. Each bus is run by an
//   identical channel FSM (IDLE, BBM, CONNECT, GRANTED, RELEASE). The channel
//   sequences the transmission-gate enables with break-before-make and settle
//   timing. It keeps the ground clamp closed while its bus is idle.
//   Optional hold-limit/timeout logic: define SKY130_FD_IO_AMUX_TIMEOUT_EN.
// Ports (top):
//   CLK, RESET_B     clock; synchronous active-low reset
//   REQ[NREQ]        request level, held until done
//   SEL[NREQ]        0 = AMUXBUS_A, 1 = AMUXBUS_B (latched when REQ rises)
//   SW_A_EN/SW_B_EN  switch enables, at most one hot per bus
//   GND_A_EN/GND_B_EN ground-clamp enables
//   GNT[NREQ]        bus connected and settled
//   BUSY_A/BUSY_B    channel not idle
//   TIMEOUT[NREQ]    one-cycle pulse on forced revoke

module sky130_fd_io__amuxbus_arbiter_ch #(
  parameter int NREQ          = 4,
  parameter int BBM_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int MAX_HOLD      = 1024
) (
  input  logic            CLK,
  input  logic            RESET_B,
  input  logic [NREQ-1:0] i_req,   // registered REQ
  input  logic [NREQ-1:0] i_elig,  // eligible for this bus
  output logic [NREQ-1:0] o_sw,
  output logic [NREQ-1:0] o_gnt,
  output logic [NREQ-1:0] o_timeout,
  output logic [NREQ-1:0] o_own,   // winner while it holds a pending or granted selection
  output logic            o_gnd,
  output logic            o_busy
);
  localparam int MAXC0 = (BBM_CYCLES > SETTLE_CYCLES) ? BBM_CYCLES : SETTLE_CYCLES;
  localparam int MAXC  = (MAXC0 > MAX_HOLD) ? MAXC0 : MAX_HOLD;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] BBM_LAST    = CW'(BBM_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
`ifdef SKY130_FD_IO_AMUX_TIMEOUT_EN
  localparam logic [CW-1:0] HOLD_LAST   = CW'(MAX_HOLD - 1);
`endif
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_BBM, S_CONNECT, S_GRANTED, S_RELEASE} state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n, w_cnt_inc;
  logic [IW-1:0]   r_win, w_win_n, r_ptr, w_ptr_n, w_rr_idx;
  logic            w_rr_found, w_req_win;
  logic [NREQ-1:0] w_to_n, w_oh_n;

  // Round robin: scan downward so the lowest offset from the pointer wins.
  always_comb begin
    int idx;
    idx        = 0;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (i_elig[idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = IW'(idx);
      end
    end
  end

  assign w_req_win = i_req[r_win];
  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_cnt_inc;
    w_win_n   = r_win;
    w_ptr_n   = r_ptr;
    w_to_n    = '0;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (w_rr_found) begin
          w_state_n = S_BBM;
          w_win_n   = w_rr_idx;
        end
      end
      S_BBM: begin
        if (!w_req_win) begin
          w_state_n = S_RELEASE;
          w_cnt_n   = '0;
        end else if (r_cnt == BBM_LAST) begin
          w_state_n = S_CONNECT;
          w_cnt_n   = '0;
          w_ptr_n   = (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
        end
      end
      S_CONNECT: begin
        if (!w_req_win) begin
          w_state_n = S_RELEASE;
          w_cnt_n   = '0;
        end else if (r_cnt == SETTLE_LAST) begin
          w_state_n = S_GRANTED;
          w_cnt_n   = '0;
        end
      end
      S_GRANTED: begin
`ifndef SKY130_FD_IO_AMUX_TIMEOUT_EN
        w_cnt_n = '0;
`endif
        if (!w_req_win) begin
          w_state_n = S_RELEASE;
          w_cnt_n   = '0;
        end
`ifdef SKY130_FD_IO_AMUX_TIMEOUT_EN
        else if (r_cnt == HOLD_LAST) begin
          w_state_n = S_RELEASE;
          w_cnt_n   = '0;
          w_to_n    = ONE << r_win;
        end
`endif
      end
      S_RELEASE: begin
        if (r_cnt == BBM_LAST) begin
          w_cnt_n = '0;
          if (w_rr_found) begin
            // Direct handoff: clamp stays off, BBM already served here.
            w_state_n = S_CONNECT;
            w_win_n   = w_rr_idx;
            w_ptr_n   = (w_rr_idx == IW'(NREQ - 1)) ? '0 : w_rr_idx + 1'b1;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  assign w_oh_n = ONE << w_win_n;

  // Outputs are registered from the next state so they change with the state.
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_win     <= '0;
      r_ptr     <= '0;
      o_sw      <= '0;
      o_gnt     <= '0;
      o_timeout <= '0;
      o_gnd     <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_win     <= w_win_n;
      r_ptr     <= w_ptr_n;
      o_sw      <= (w_state_n == S_CONNECT || w_state_n == S_GRANTED) ? w_oh_n : '0;
      o_gnt     <= (w_state_n == S_GRANTED) ? w_oh_n : '0;
      o_timeout <= w_to_n;
      o_gnd     <= (w_state_n == S_IDLE);
      o_busy    <= (w_state_n != S_IDLE);
    end
  end

  assign o_own = (r_state == S_BBM || r_state == S_CONNECT || r_state == S_GRANTED)
                 ? (ONE << r_win) : '0;
endmodule

module sky130_fd_io__amuxbus_arbiter #(
  parameter int NREQ          = 4,
  parameter int BBM_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int MAX_HOLD      = 1024
) (
  input  logic            CLK,
  input  logic            RESET_B,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] SEL,
  output logic [NREQ-1:0] SW_A_EN,
  output logic [NREQ-1:0] SW_B_EN,
  output logic            GND_A_EN,
  output logic            GND_B_EN,
  output logic [NREQ-1:0] GNT,
  output logic            BUSY_A,
  output logic            BUSY_B,
  output logic [NREQ-1:0] TIMEOUT
);
  logic [NREQ-1:0]       r_req, r_sel, w_lock;
  logic [1:0][NREQ-1:0]  w_elig, w_sw, w_gnt, w_to, w_own;
  logic [1:0]            w_gnd, w_busy;

  // SEL is captured on the sample where REQ first reads high and held
  // for the whole request.
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      r_req <= '0;
      r_sel <= '0;
    end else begin
      r_req <= REQ;
      r_sel <= (REQ & ~r_req & SEL) | (r_sel & ~(REQ & ~r_req));
    end
  end

`ifdef SKY130_FD_IO_AMUX_TIMEOUT_EN
  logic [NREQ-1:0] r_lock;
  // Lockout after a forced revoke, cleared once REQ has been seen low.
  always_ff @(posedge CLK) begin
    if (!RESET_B) r_lock <= '0;
    else          r_lock <= (r_lock | TIMEOUT) & r_req;
  end
  assign w_lock = r_lock;
`else
  assign w_lock = '0;
`endif

  // Channel 0 = AMUXBUS_A, channel 1 = AMUXBUS_B. A requester owning the
  // other bus is masked out so it never holds both.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    assign w_elig[g] = r_req & ((g == 0) ? ~r_sel : r_sel) & ~w_lock & ~w_own[1-g];
    sky130_fd_io__amuxbus_arbiter_ch #(
      .NREQ(NREQ), .BBM_CYCLES(BBM_CYCLES),
      .SETTLE_CYCLES(SETTLE_CYCLES), .MAX_HOLD(MAX_HOLD)
    ) u_ch (
      .CLK(CLK), .RESET_B(RESET_B),
      .i_req(r_req), .i_elig(w_elig[g]),
      .o_sw(w_sw[g]), .o_gnt(w_gnt[g]), .o_timeout(w_to[g]),
      .o_own(w_own[g]), .o_gnd(w_gnd[g]), .o_busy(w_busy[g])
    );
  end

  assign SW_A_EN  = w_sw[0];
  assign SW_B_EN  = w_sw[1];
  assign GND_A_EN = w_gnd[0];
  assign GND_B_EN = w_gnd[1];
  assign GNT      = w_gnt[0] | w_gnt[1];
  assign BUSY_A   = w_busy[0];
  assign BUSY_B   = w_busy[1];
  assign TIMEOUT  = w_to[0] | w_to[1];
endmodule
